// File: rtl/int_async_crossing_sink_multi.sv
// Receive side of a multi-channel interrupt crossing: per-channel synchronizer,
// optional glitch filter, and a level or edge-latched output mode.
module int_async_crossing_sink_multi #(
   parameter int WIDTH      = 1,
   parameter int SYNC_DEPTH = 3,
   parameter int FILTER     = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] auto_in_sync,
   input  logic [WIDTH-1:0] mode,
   input  logic [WIDTH-1:0] clear,
   output logic [WIDTH-1:0] auto_out
);

   logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                 sync_last;
   logic [WIDTH-1:0]                 filt;
   logic [WIDTH-1:0]                 filt_dly_q;
   logic [WIDTH-1:0]                 rise;
   logic [WIDTH-1:0]                 pending_q;
   logic [WIDTH-1:0]                 pending_d;

   // Plain flop chain: nothing may sit between stages or metastability escapes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], auto_in_sync};
      end
   end

   assign sync_last = sync_q[SYNC_DEPTH-1];

   if (FILTER == 0) begin : g_bypass
      assign filt = sync_last;
   end else begin : g_filter
      localparam int CW = $clog2(FILTER + 1);
      logic [WIDTH-1:0][CW-1:0] cnt_q;
      logic [WIDTH-1:0]         filt_q;

      // The counter restarts whenever the input agrees with the filtered level,
      // so only FILTER consecutive disagreeing cycles can move it.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt_q  <= '0;
            filt_q <= '0;
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (sync_last[i] == filt_q[i]) begin
                  cnt_q[i] <= '0;
               end else if (cnt_q[i] == CW'(FILTER - 1)) begin
                  filt_q[i] <= sync_last[i];
                  cnt_q[i]  <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end

      assign filt = filt_q;
   end

   assign rise = filt & ~filt_dly_q;

   // Set beats clear; level-mode channels keep pending parked at zero.
   assign pending_d = mode & (rise | (pending_q & ~clear));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt_dly_q <= '0;
         pending_q  <= '0;
      end else begin
         filt_dly_q <= filt;
         pending_q  <= pending_d;
      end
   end

   assign auto_out = (mode & pending_q) | (~mode & filt);

endmodule

// File: tb/tb_int_async_crossing_sink_multi.sv
// Scoreboard bench: stimulus pushes (dut, cycle, mask, value) expectations,
// a negedge monitor checks each one on its due cycle.
module tb_int_async_crossing_sink_multi;

   logic        clock;
   logic        reset;
   logic [3:0]  in0, mode0, clr0, out0;
   logic [3:0]  in4, mode4, clr4, out4;
   logic [31:0] in32, md32, clr32, out32;

   int_async_crossing_sink_multi #(.WIDTH(4), .SYNC_DEPTH(3), .FILTER(0)) u_f0 (
      .clock(clock), .reset(reset), .auto_in_sync(in0), .mode(mode0),
      .clear(clr0), .auto_out(out0));

   int_async_crossing_sink_multi #(.WIDTH(4), .SYNC_DEPTH(3), .FILTER(4)) u_f4 (
      .clock(clock), .reset(reset), .auto_in_sync(in4), .mode(mode4),
      .clear(clr4), .auto_out(out4));

   int_async_crossing_sink_multi #(.WIDTH(32), .SYNC_DEPTH(3), .FILTER(2)) u_f2 (
      .clock(clock), .reset(reset), .auto_in_sync(in32), .mode(md32),
      .clear(clr32), .auto_out(out32));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          dut;
      int          at;
      logic [31:0] mask;
      logic [31:0] val;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [31:0] pick(input int dut);
      if (dut == 0) return {28'd0, out0};
      if (dut == 1) return {28'd0, out4};
      return out32;
   endfunction

   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            logic [31:0] act;
            act = pick(sb[i].dut) & sb[i].mask;
            n_cmp++;
            if (sb[i].at < cyc) begin
               n_err++;
               $display("FAIL %s dut%0d: expectation for cycle %0d expired at %0d", sb[i].nm, sb[i].dut, sb[i].at, cyc);
            end else if (act !== (sb[i].val & sb[i].mask)) begin
               n_err++;
               $display("FAIL %s dut%0d cyc%0d: got %h want %h", sb[i].nm, sb[i].dut, cyc, act, sb[i].val & sb[i].mask);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic expect_out(input int dut, input int at, input logic [31:0] mask,
                             input logic [31:0] val, input string nm);
      exp_t e;
      e.dut = dut; e.at = at; e.mask = mask; e.val = val; e.nm = nm;
      sb.push_back(e);
   endtask

   // Reference for the 32-channel random run (SYNC_DEPTH=3, FILTER=2).
   localparam int RF = 2;
   logic [31:0] m_s0, m_s1, m_s2, m_filt, m_filtd, m_pend;
   int          m_run [32];

   task automatic model_step(input logic [31:0] in, input logic [31:0] md, input logic [31:0] clr);
      logic [31:0] nf, np;
      nf = m_filt;
      np = '0;
      for (int ch = 0; ch < 32; ch++) begin
         if (md[ch]) np[ch] = (m_filt[ch] & ~m_filtd[ch]) | (m_pend[ch] & ~clr[ch]);
         if (m_s2[ch] == m_filt[ch]) begin
            m_run[ch] = 0;
         end else begin
            m_run[ch] = m_run[ch] + 1;
            if (m_run[ch] == RF) begin
               nf[ch]    = m_s2[ch];
               m_run[ch] = 0;
            end
         end
      end
      m_filtd = m_filt;
      m_filt  = nf;
      m_pend  = np;
      m_s2    = m_s1;
      m_s1    = m_s0;
      m_s0    = in;
   endtask

   initial begin
      int k, c, j, m, p, n;
      reset = 1'b1;
      in0 = '0; mode0 = '0; clr0 = '0;
      in4 = '0; mode4 = '0; clr4 = '0;
      in32 = '0; md32 = '0; clr32 = '0;
      tick();
      expect_out(0, cyc, 32'hF, 32'h0, "rst_f0");
      expect_out(1, cyc, 32'hF, 32'h0, "rst_f4");
      expect_out(2, cyc, '1, 32'h0, "rst_f2");
      tick();
      reset = 1'b0;
      expect_out(0, cyc, 32'hF, 32'h0, "rel0");
      expect_out(0, cyc + 1, 32'hF, 32'h0, "rel1");
      ticks(2);

      // Level mode, no filter: three-edge latency.
      k = cyc;
      in0 = 4'b0101;
      expect_out(0, k + 2, 32'hF, 32'h0, "lvl_edge2");
      expect_out(0, k + 3, 32'hF, 32'h5, "lvl_edge3");
      expect_out(0, k + 5, 32'hF, 32'h5, "lvl_hold");
      ticks(6);
      reset = 1'b1;
      expect_out(0, cyc, 32'hF, 32'h0, "rst_mid");
      tick();
      reset = 1'b0;
      k = cyc;
      expect_out(0, k + 2, 32'hF, 32'h0, "rst_noreplay");
      expect_out(0, k + 3, 32'hF, 32'h5, "rst_resync");
      ticks(4);
      in0 = 4'b0000;
      ticks(5);

      // Edge latch on ch1.
      mode0 = 4'b0010;
      ticks(2);
      k = cyc;
      in0[1] = 1'b1;
      ticks(2);
      in0[1] = 1'b0;
      expect_out(0, k + 3, 32'h2, 32'h0, "edge_pre");
      expect_out(0, k + 4, 32'h2, 32'h2, "edge_set");
      expect_out(0, k + 8, 32'h2, 32'h2, "edge_stick");
      ticks(7);
      c = cyc;
      clr0 = 4'b0010;
      expect_out(0, c, 32'h2, 32'h2, "clr_before");
      expect_out(0, c + 1, 32'h2, 32'h0, "clr_after");
      tick();
      clr0 = '0;
      ticks(4);

      // Set beats clear on the same edge.
      k = cyc;
      in0[1] = 1'b1;
      ticks(2);
      in0[1] = 1'b0;
      tick();
      clr0 = 4'b0010;
      tick();
      clr0 = '0;
      expect_out(0, k + 4, 32'h2, 32'h2, "setwins0");
      expect_out(0, k + 5, 32'h2, 32'h2, "setwins1");
      ticks(3);
      j = cyc;
      in0[1] = 1'b1;
      ticks(2);
      in0[1] = 1'b0;
      expect_out(0, j + 4, 32'h2, 32'h2, "absorb0");
      expect_out(0, j + 6, 32'h2, 32'h2, "absorb1");
      ticks(5);
      c = cyc;
      clr0 = 4'b0010;
      expect_out(0, c + 1, 32'h2, 32'h0, "clr_once");
      tick();
      clr0 = '0;
      ticks(3);

      // Mode switching on ch2.
      mode0 = 4'b0110;
      ticks(2);
      k = cyc;
      in0[2] = 1'b1;
      ticks(2);
      in0[2] = 1'b0;
      expect_out(0, k + 4, 32'h4, 32'h4, "ms_pend");
      ticks(4);
      c = cyc;
      mode0[2] = 1'b0;
      expect_out(0, c, 32'h4, 32'h0, "ms_lvl0");
      expect_out(0, c + 1, 32'h4, 32'h0, "ms_lvl1");
      ticks(2);
      j = cyc;
      in0[2] = 1'b1;
      expect_out(0, j + 2, 32'h4, 32'h0, "ms_lvl_lat");
      expect_out(0, j + 3, 32'h4, 32'h4, "ms_lvl_high");
      ticks(5);
      m = cyc;
      mode0[2] = 1'b1;
      expect_out(0, m, 32'h4, 32'h0, "ms_noedge0");
      expect_out(0, m + 5, 32'h4, 32'h0, "ms_noedge1");
      ticks(6);
      p = cyc;
      in0[2] = 1'b0;
      ticks(3);
      n = cyc;
      in0[2] = 1'b1;
      expect_out(0, n + 3, 32'h4, 32'h0, "ms_newedge0");
      expect_out(0, n + 4, 32'h4, 32'h4, "ms_newedge1");
      ticks(6);

      // Filter = 4: short glitch rejected, exact-length pulse accepted.
      mode4 = 4'b0010;
      k = cyc;
      in4[0] = 1'b1;
      ticks(3);
      in4[0] = 1'b0;
      expect_out(1, k + 7, 32'h1, 32'h0, "glitch3_a");
      expect_out(1, k + 9, 32'h1, 32'h0, "glitch3_b");
      ticks(10);
      k = cyc;
      in4[0] = 1'b1;
      ticks(4);
      in4[0] = 1'b0;
      expect_out(1, k + 6, 32'h1, 32'h0, "pulse4_pre");
      expect_out(1, k + 7, 32'h1, 32'h1, "pulse4_pass");
      ticks(14);
      k = cyc;
      in4 = 4'b0011;
      expect_out(1, k + 6, 32'h1, 32'h0, "fhold_6");
      expect_out(1, k + 7, 32'h1, 32'h1, "fhold_7");
      expect_out(1, k + 7, 32'h2, 32'h0, "fedge_7");
      expect_out(1, k + 8, 32'h2, 32'h2, "fedge_8");
      ticks(10);
      k = cyc;
      in4 = 4'b0000;
      expect_out(1, k + 6, 32'h1, 32'h1, "flow_6");
      expect_out(1, k + 7, 32'h1, 32'h0, "flow_7");
      expect_out(1, k + 10, 32'h2, 32'h2, "ffall_noeff");
      ticks(11);
      c = cyc;
      clr4 = 4'b0010;
      expect_out(1, c + 1, 32'h2, 32'h0, "fclr");
      tick();
      clr4 = '0;
      ticks(2);

      // 32 independent channels, random activity, against the reference.
      reset = 1'b1;
      m_s0 = '0; m_s1 = '0; m_s2 = '0; m_filt = '0; m_filtd = '0; m_pend = '0;
      for (int ch = 0; ch < 32; ch++) m_run[ch] = 0;
      tick();
      reset = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (t % 64 == 0) md32 = $urandom;
         in32  = in32 ^ ($urandom & $urandom);
         clr32 = $urandom & $urandom & $urandom;
         expect_out(2, cyc, '1, (md32 & m_pend) | (~md32 & m_filt), "rand");
         tick();
         model_step(in32, md32, clr32);
      end

      ticks(4);
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
